// File: rtl/gemm_io_wrapper.sv
// Self-running 4x4 unsigned GEMM: LFSR-generated operands, results streamed on
// the D_out write port and folded onto a few pins so the datapath is kept.
module gemm_io_wrapper #(
    parameter int unsigned N    = 4,
    parameter int unsigned DW   = 8,
    parameter int unsigned OW   = 32,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk_p,
    input  logic       clk_n,
    input  logic       ap_rst,
    output logic       probe_out,
    output logic [3:0] data_out,
    output logic       data_valid
);

    localparam int unsigned NN       = N * N;
    localparam int unsigned LOAD_LEN = 2 * NN;
    localparam int unsigned COMP_LEN = NN * N;
    localparam int unsigned CNT_W    = 6;
    localparam int unsigned PW       = 2 * DW;
    localparam int unsigned LW       = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMPUTE
    } state_t;

    // Differential input buffer; only the positive leg carries the clock in simulation.
    logic ap_clk;
    logic unused_clk_n;
    assign ap_clk       = clk_p;
    assign unused_clk_n = clk_n;

    state_t           state;
    state_t           state_nxt;
    logic [LW-1:0]    lfsr;
    logic             lfsr_fb;
    logic [CNT_W-1:0] cnt;
    logic [OW-1:0]    acc;
    logic [OW-1:0]    acc_nxt;
    logic [DW-1:0]    a_mem [NN];
    logic [DW-1:0]    b_mem [NN];
    logic [DW-1:0]    a_op;
    logic [DW-1:0]    b_op;
    logic [PW-1:0]    prod;
    logic [1:0]       row_i;
    logic [1:0]       col_j;
    logic [1:0]       k_idx;
    logic             load_last;
    logic             comp_last;
    logic             D_out_write;
    logic [OW-1:0]    D_out_din;

    function automatic logic [3:0] nib_fold(input logic [OW-1:0] w);
        logic [3:0] r;
        r = 4'd0;
        for (int unsigned n = 0; n < OW / 4; n++) begin
            r = r ^ w[4*n +: 4];
        end
        return r;
    endfunction

    // Counter decode: during COMPUTE cnt = {i, j, k}, element order row-major.
    always_comb begin
        row_i     = cnt[5:4];
        col_j     = cnt[3:2];
        k_idx     = cnt[1:0];
        load_last = (cnt == CNT_W'(LOAD_LEN - 1));
        comp_last = (cnt == CNT_W'(COMP_LEN - 1));
        lfsr_fb   = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
        a_op      = a_mem[{row_i, k_idx}];
        b_op      = b_mem[{k_idx, col_j}];
        prod      = PW'(a_op) * PW'(b_op);
        acc_nxt   = ((k_idx == 2'd0) ? OW'(0) : acc) + OW'(prod);
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = LOAD;
            LOAD:    if (load_last) state_nxt = COMPUTE;
            COMPUTE: if (comp_last) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    // Counters, LFSR, accumulator and the D_out write port.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            lfsr        <= SEED;
            cnt         <= '0;
            acc         <= '0;
            D_out_write <= 1'b0;
            D_out_din   <= '0;
        end else begin
            D_out_write <= 1'b0;
            case (state)
                IDLE: cnt <= '0;
                LOAD: begin
                    lfsr <= {lfsr_fb, lfsr[LW-1:1]};
                    cnt  <= load_last ? CNT_W'(0) : cnt + CNT_W'(1);
                end
                COMPUTE: begin
                    acc <= acc_nxt;
                    cnt <= comp_last ? CNT_W'(0) : cnt + CNT_W'(1);
                    if (k_idx == 2'd3) begin
                        D_out_din   <= acc_nxt;
                        D_out_write <= 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Operand storage: first half of LOAD fills A, second half fills B.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst && state == LOAD) begin
            if (!cnt[4]) begin
                a_mem[cnt[3:0]] <= lfsr[DW-1:0];
            end else begin
                b_mem[cnt[3:0]] <= lfsr[DW-1:0];
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            data_valid <= 1'b0;
            data_out   <= 4'd0;
            probe_out  <= 1'b0;
        end else begin
            data_valid <= D_out_write;
            if (D_out_write) begin
                data_out  <= nib_fold(D_out_din);
                probe_out <= probe_out ^ (^D_out_din);
            end
        end
    end

endmodule

// File: tb/tb_gemm_io_wrapper.sv
// Scoreboard bench for gemm_io_wrapper: expected D_out words and write cycles
// come from an independent LFSR + matrix model; a negedge monitor compares.
module tb_gemm_io_wrapper;

    typedef struct {
        logic [31:0] d;
        int unsigned cyc;
    } exp_t;

    logic       clk_p;
    logic       clk_n;
    logic       ap_rst;
    logic       probe_out;
    logic [3:0] data_out;
    logic       data_valid;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    logic        rst_q    = 1'b0;
    bit          live     = 1'b0;
    exp_t        q[$];

    gemm_io_wrapper dut (
        .clk_p      (clk_p),
        .clk_n      (clk_n),
        .ap_rst     (ap_rst),
        .probe_out  (probe_out),
        .data_out   (data_out),
        .data_valid (data_valid)
    );

    assign clk_n = ~clk_p;

    initial begin
        clk_p = 1'b0;
        forever #5 clk_p = ~clk_p;
    end

    // Cycle 0 is the cycle following the last edge that sampled reset.
    always @(posedge clk_p) begin
        rst_q <= ap_rst;
        if (ap_rst) begin
            cyc  <= 0;
            live <= 1'b1;
        end else begin
            cyc <= cyc + 1;
        end
    end

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
        end
    endtask

    function automatic logic [3:0] fold(input logic [31:0] w);
        logic [3:0] r;
        r = 4'd0;
        for (int n = 0; n < 8; n++) r = r ^ w[4*n +: 4];
        return r;
    endfunction

    // Push expected results for `runs` runs starting from the reset seed.
    task automatic arm(input int runs);
        logic [15:0] l;
        logic        fb;
        int unsigned a [16];
        int unsigned b [16];
        int unsigned s;
        exp_t        e;
        l = 16'hACE1;
        for (int r = 0; r < runs; r++) begin
            for (int n = 0; n < 32; n++) begin
                if (n < 16) a[n] = int'(l[7:0]);
                else        b[n - 16] = int'(l[7:0]);
                fb = l[0] ^ l[2] ^ l[3] ^ l[5];
                l  = {fb, l[15:1]};
            end
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    s = 0;
                    for (int k = 0; k < 4; k++) s += a[i*4 + k] * b[k*4 + j];
                    e.d   = 32'(s);
                    e.cyc = 32'(37 + 96*r + 4*(i*4 + j));
                    q.push_back(e);
                end
            end
        end
    endtask

    // Monitor: pops the scoreboard on every D_out write, checks pin fold a cycle later.
    bit          pending = 1'b0;
    bit          prev_wr = 1'b0;
    logic        exp_par = 1'b0;
    logic [31:0] last_d  = 32'd0;

    always @(negedge clk_p) begin
        exp_t e;
        if (live) begin
            if (rst_q) begin
                check(probe_out == 1'b0, "rst_probe_out", 32'(probe_out), 32'd0);
                check(data_out == 4'd0, "rst_data_out", 32'(data_out), 32'd0);
                check(data_valid == 1'b0, "rst_data_valid", 32'(data_valid), 32'd0);
                check(dut.D_out_write == 1'b0, "rst_d_out_write", 32'(dut.D_out_write), 32'd0);
                check(dut.D_out_din == 32'd0, "rst_d_out_din", dut.D_out_din, 32'd0);
                pending = 1'b0;
                prev_wr = 1'b0;
                exp_par = 1'b0;
            end else begin
                check(!$isunknown({probe_out, data_out, data_valid, dut.D_out_write, dut.D_out_din}),
                      "no_x", 32'(data_out), 32'(data_out));
                check(data_valid == pending, "data_valid", 32'(data_valid), 32'(pending));
                if (pending) begin
                    check(data_out == fold(last_d), "data_out", 32'(data_out), 32'(fold(last_d)));
                    check(probe_out == exp_par, "probe_out", 32'(probe_out), 32'(exp_par));
                end
                if (dut.D_out_write === 1'b1) begin
                    check(!prev_wr, "write_back_to_back", 32'd1, 32'd0);
                    check(dut.D_out_din[31:18] == 14'd0, "din_upper_zero",
                          dut.D_out_din, dut.D_out_din & 32'h3FFFF);
                    if (q.size() == 0) begin
                        check(1'b0, "unexpected_write", dut.D_out_din, 32'd0);
                        last_d = dut.D_out_din;
                    end else begin
                        e = q.pop_front();
                        check(dut.D_out_din == e.d, "d_out_din", dut.D_out_din, e.d);
                        check(cyc == e.cyc, "write_cycle", cyc, e.cyc);
                        last_d = e.d;
                    end
                    exp_par = exp_par ^ (^last_d);
                    pending = 1'b1;
                    prev_wr = 1'b1;
                end else begin
                    pending = 1'b0;
                    prev_wr = 1'b0;
                end
            end
        end
    end

    initial begin
        bit hit;
        ap_rst = 1'b1;
        repeat (30) @(posedge clk_p);
        #1;
        ap_rst = 1'b0;
        arm(1);

        // Reset again inside the first COMPUTE phase.
        hit = 1'b0;
        for (int t = 0; t < 200 && !hit; t++) begin
            @(posedge clk_p);
            #1;
            if (cyc == 60) hit = 1'b1;
        end
        check(hit, "reach_cycle_60", cyc, 32'd60);
        ap_rst = 1'b1;
        @(posedge clk_p);
        #1;
        ap_rst = 1'b0;
        q.delete();
        arm(63);

        for (int t = 0; t < 63*96 + 300 && q.size() != 0; t++) @(posedge clk_p);
        repeat (4) @(posedge clk_p);
        check(q.size() == 0, "scoreboard_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
